// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl: write/read-back BIST initiator for a single-port SRAM
module sram_bist_ctrl #(
    parameter int DW     = 16,
    parameter int AW     = 7,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] seed,
    input  logic [DW-1:0] sram_outbits,
    output logic [DW-1:0] sram_inbits,
    output logic [AW-1:0] sram_addr,
    output logic          sram_we,
    output logic          sram_re,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_count,
    output logic [AW-1:0] fail_addr
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [AW-1:0] cnt;
    logic [1:0]    mode_q;
    logic [DW-1:0] lfsr, lfsr_init, lfsr_nx, seed_eff, pat;
    logic [DW-1:0] exp_p [RD_LAT+1];
    logic [AW-1:0] adr_p [RD_LAT+1];
    logic [RD_LAT:0] vld_p;
    logic last, accept, miss;
    logic [DW-1:0] inbits_n;
    logic [AW-1:0] addr_n;
    logic we_n, re_n, busy_n, done_n;

    assign last     = cnt == AW'(DEPTH - 1);
    assign accept   = state == IDLE && start;
    assign seed_eff = seed == '0 ? DW'(1) : seed;
    assign lfsr_nx  = {lfsr[DW-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign miss     = vld_p[RD_LAT] && sram_outbits != exp_p[RD_LAT];

    // expected word for the address handled this cycle
    always_comb begin
        pat = mode_q == 2'd0 ? {{(DW-AW){1'b0}}, cnt} :
              mode_q == 2'd1 ? (cnt[0] ? {(DW/2){2'b10}} : {(DW/2){2'b01}}) :
              mode_q == 2'd2 ? lfsr : ~{{(DW-AW){1'b0}}, cnt};
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? WRITE : IDLE;
            WRITE:   state_n = last ? READ : WRITE;
            READ:    state_n = last ? DRAIN : READ;
            DRAIN:   state_n = cnt == AW'(RD_LAT - 1) ? DONE : DRAIN;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        we_n     = state == WRITE;
        re_n     = state == READ;
        addr_n   = (we_n || re_n) ? cnt : sram_addr;
        inbits_n = we_n ? pat : sram_inbits;
        busy_n   = state == IDLE ? start : state != DONE;
        done_n   = state == DONE;
    end

    // output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            sram_we     <= 1'b0;
            sram_re     <= 1'b0;
            sram_addr   <= '0;
            sram_inbits <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            sram_we     <= we_n;
            sram_re     <= re_n;
            sram_addr   <= addr_n;
            sram_inbits <= inbits_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    // word counter, pattern source and expected-data pipeline aligned to read latency
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            mode_q    <= '0;
            lfsr      <= '0;
            lfsr_init <= '0;
            vld_p     <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                exp_p[k] <= '0;
                adr_p[k] <= '0;
            end
        end else begin
            cnt <= (state == WRITE || state == READ || state == DRAIN) ? cnt + 1'b1 : '0;
            if (accept) begin
                mode_q    <= mode;
                lfsr      <= seed_eff;
                lfsr_init <= seed_eff;
            end else if (state == WRITE && last) begin
                lfsr <= lfsr_init;
            end else if (state == WRITE || state == READ) begin
                lfsr <= lfsr_nx;
            end
            vld_p    <= {vld_p[RD_LAT-1:0], state == READ};
            exp_p[0] <= pat;
            adr_p[0] <= cnt;
            for (int k = 1; k <= RD_LAT; k++) begin
                exp_p[k] <= exp_p[k-1];
                adr_p[k] <= adr_p[k-1];
            end
        end
    end

    // mismatch counting, first failing address and final verdict
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else if (accept) begin
            err_count <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else begin
            if (miss && err_count != 8'hFF) err_count <= err_count + 1'b1;
            if (miss && err_count == '0) fail_addr <= adr_p[RD_LAT];
            if (state == DONE) pass <= err_count == '0 && !miss;
        end
    end
endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb_sram_bist_ctrl: directed and randomized checks of the SRAM BIST controller against a reference model
module tb_sram_bist_ctrl;
    localparam int DW = 16, AW = 7, DEPTH = 128, RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = '0;
    logic [DW-1:0] seed = '0;
    logic [DW-1:0] sram_outbits;
    logic [DW-1:0] sram_inbits;
    logic [AW-1:0] sram_addr;
    logic          sram_we, sram_re, busy, done, pass;
    logic [7:0]    err_count;
    logic [AW-1:0] fail_addr;

    int checks = 0, errors = 0, cyc = 0;
    logic [15:0] mem [DEPTH];
    bit sa_en = 0, al_en = 0;
    int sa_addr = 0, sa_bit = 0, al_lo = 0, al_hi = 0;

    sram_bist_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .sram_outbits(sram_outbits), .sram_inbits(sram_inbits), .sram_addr(sram_addr),
        .sram_we(sram_we), .sram_re(sram_re), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model, one-cycle read latency, optional stuck-at-0 bit and write aliasing
    always @(posedge clk) begin
        if (sram_we) begin
            mem[sram_addr] <= sram_inbits;
            if (al_en && int'(sram_addr) == al_hi) mem[al_lo] <= sram_inbits;
        end
        if (sram_re)
            sram_outbits <= (sa_en && int'(sram_addr) == sa_addr) ? mem[sram_addr] & ~(16'h1 << sa_bit) : mem[sram_addr];
    end

    function automatic logic [15:0] pat(input logic [1:0] m, input logic [15:0] s, input int i);
        logic [15:0] l;
        l = (s == 16'h0) ? 16'h0001 : s;
        if (m == 2'd0) return 16'(i);
        if (m == 2'd1) return (i % 2 == 1) ? 16'hAAAA : 16'h5555;
        if (m == 2'd3) return ~16'(i);
        for (int k = 0; k < i; k++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return l;
    endfunction

    task automatic compute_expected(input logic [1:0] m, input logic [15:0] s, output int ec, output int fa);
        logic [15:0] img [DEPTH];
        logic [15:0] rd;
        ec = 0;
        fa = 0;
        for (int a = 0; a < DEPTH; a++) begin
            img[a] = pat(m, s, a);
            if (al_en && a == al_hi) img[al_lo] = pat(m, s, a);
        end
        for (int a = 0; a < DEPTH; a++) begin
            rd = img[a];
            if (sa_en && a == sa_addr) rd = rd & ~(16'h1 << sa_bit);
            if (rd !== pat(m, s, a)) begin
                if (ec == 0) fa = a;
                ec++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_test(input string tag, input logic [1:0] m, input logic [15:0] s, input bit late,
                            output logic p_o, output int ec_o, output int fa_o, output logic [15:0] w0);
        int t0, k, nw, nr, nd, fw, fr, tdone, bad_w, bad_r, both, nb, exp_ec, exp_fa;
        logic busy_o;
        compute_expected(m, s, exp_ec, exp_fa);
        nw = 0; nr = 0; nd = 0; fw = -1; fr = -1; tdone = -1;
        bad_w = 0; bad_r = 0; both = 0; nb = 0; busy_o = 1'b1;
        p_o = 1'bx; ec_o = -1; fa_o = -1; w0 = 16'hxxxx;
        @(negedge clk);
        mode = m; seed = s; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
        mode = ~m; seed = ~s;
        for (int n = 0; n <= 2 * DEPTH + RD_LAT + 20; n++) begin
            k = cyc - t0;
            if (late && k == 9) start = 1'b1;
            if (late && k == 10) start = 1'b0;
            if (sram_we) begin
                if (nw == 0) begin fw = k; w0 = sram_inbits; end
                if (int'(sram_addr) != nw || sram_inbits !== pat(m, s, nw)) bad_w++;
                nw++;
            end
            if (sram_re) begin
                if (nr == 0) fr = k;
                if (int'(sram_addr) != nr) bad_r++;
                nr++;
            end
            if (sram_we && sram_re) both++;
            if (!done && !busy) nb++;
            if (done) begin
                nd++; tdone = k; p_o = pass; ec_o = int'(err_count); fa_o = int'(fail_addr); busy_o = busy;
                break;
            end
            @(posedge clk); #1;
        end
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check({tag, " first_write"}, fw, 1);
        check({tag, " first_read"}, fr, DEPTH + 1);
        check({tag, " done_cycle"}, tdone, 2 * DEPTH + RD_LAT + 1);
        check({tag, " done_pulses"}, nd, 1);
        check({tag, " writes"}, nw, DEPTH);
        check({tag, " reads"}, nr, DEPTH);
        check({tag, " bad_write_beats"}, bad_w, 0);
        check({tag, " bad_read_addrs"}, bad_r, 0);
        check({tag, " we_and_re"}, both, 0);
        check({tag, " busy_gaps"}, nb, 0);
        check({tag, " busy_at_done"}, busy_o, 0);
        check({tag, " err_count"}, ec_o, exp_ec);
        check({tag, " fail_addr"}, fa_o, exp_fa);
        check({tag, " pass"}, p_o, exp_ec == 0);
    endtask

    initial begin
        logic p;
        int ec, fa, found;
        logic [15:0] w0;
        logic [1:0] m;
        logic [15:0] s;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst pass", pass, 0);
        check("rst err_count", err_count, 0);
        check("rst fail_addr", fail_addr, 0);
        check("rst we", sram_we, 0);
        check("rst re", sram_re, 0);
        check("rst addr", sram_addr, 0);
        check("rst inbits", sram_inbits, 0);
        @(negedge clk);
        rst = 1'b1;

        run_test("m0 clean", 2'd0, 16'h1234, 0, p, ec, fa, w0);
        check("m0 clean pass", p, 1);
        check("m0 clean first word", w0, 16'h0000);

        sa_en = 1; sa_addr = 'h15; sa_bit = 3;
        run_test("m3 stuck", 2'd3, 16'h0, 0, p, ec, fa, w0);
        check("m3 stuck pass", p, 0);
        check("m3 stuck err_count", ec, 1);
        check("m3 stuck fail_addr", fa, 'h15);
        check("m3 first word", w0, 16'hFFFF);
        run_test("m0 stuck", 2'd0, 16'h0, 0, p, ec, fa, w0);
        check("m0 stuck pass", p, 1);
        sa_en = 0;

        run_test("m2 seed0", 2'd2, 16'h0000, 0, p, ec, fa, w0);
        check("m2 seed0 first word", w0, 16'h0001);
        check("m2 seed0 pass", p, 1);

        al_en = 1; al_lo = 'h40; al_hi = 'h41;
        run_test("m1 alias", 2'd1, 16'h0, 0, p, ec, fa, w0);
        check("m1 alias err_count", ec, 1);
        check("m1 alias fail_addr", fa, 'h40);
        check("m1 alias pass", p, 0);
        al_en = 0;

        sa_en = 1; sa_addr = 5; sa_bit = 0;
        @(negedge clk);
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 3 * DEPTH; n++) begin
            @(posedge clk); #1;
            if (sram_re && sram_addr == 7'd50) begin found = 1; break; end
        end
        check("abort reached i50", found, 1);
        check("abort err before", err_count, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort busy", busy, 0);
        check("abort we", sram_we, 0);
        check("abort re", sram_re, 0);
        check("abort done", done, 0);
        check("abort err_count", err_count, 0);
        rst = 1'b1;
        found = 0;
        for (int n = 0; n < 2 * DEPTH; n++) begin
            @(posedge clk); #1;
            if (done || busy || sram_re || sram_we) found++;
        end
        check("abort stays idle", found, 0);
        sa_en = 0;
        run_test("after abort", 2'd0, 16'h0, 0, p, ec, fa, w0);
        check("after abort pass", p, 1);

        run_test("late start", 2'd2, 16'hACE1, 1, p, ec, fa, w0);
        check("late start first word", w0, 16'hACE1);
        check("late start pass", p, 1);

        for (int r = 0; r < 6; r++) begin
            m = 2'($urandom_range(0, 3));
            s = 16'($urandom);
            sa_en = 1'($urandom_range(0, 1));
            sa_addr = int'($urandom_range(0, DEPTH - 1));
            sa_bit = int'($urandom_range(0, 15));
            al_en = 1'($urandom_range(0, 1));
            al_lo = int'($urandom_range(0, DEPTH - 1));
            al_hi = (al_lo + int'($urandom_range(1, DEPTH - 1))) % DEPTH;
            run_test($sformatf("rnd%0d", r), m, s, 0, p, ec, fa, w0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
Built-in self-test initiator for the 16x128 single-port SRAM (sram16x128). It drives the write side of the SRAM interface: fills every address with a selectable data pattern, reads every address back, and compares each returned word against the regenerated expected value. It reports pass/fail, an error count and the first failing address to the surrounding test logic.

Parameters:
DW, 16, data width; matches the SRAM word.
AW, 7, address width.
DEPTH, 128, number of words tested; must equal 2**AW.
RD_LAT, 1, cycles from a read issue (re=1 with addr) to valid SRAM data; allowed range 1..4.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-low.
start  input  1  one-cycle request to begin a test; sampled only in IDLE.
mode  input  2  pattern select, latched at start.
seed  input  DW  LFSR seed for mode 2, latched at start.
sram_outbits  input  DW  read data returned by the SRAM.
sram_inbits  output  DW  write data to the SRAM.
sram_addr  output  AW  SRAM address.
sram_we  output  1  SRAM write enable.
sram_re  output  1  SRAM read enable.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse at test end.
pass  output  1  result; valid from done until the next accepted start.
err_count  output  8  number of mismatching words, 0..128.
fail_addr  output  AW  address of the first mismatch; 0 if none.

Behaviour:
- Reset (rst=0 at an edge): state IDLE. All outputs 0, except pass=0. LFSR and pipelines are cleared. Reset is honoured in any state and aborts a test mid-operation with no done pulse.
- States: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE. All SRAM outputs are registered.
- IDLE: if start=1, latch mode and seed, clear err_count, fail_addr and the fail flag, set busy=1, and go to WRITE. A start in any other state is ignored.
- WRITE: lasts DEPTH cycles. In cycle i, sram_we=1, sram_re=0, sram_addr=i, sram_inbits=pattern(i). After i=DEPTH-1, go to READ.
- READ: lasts DEPTH cycles. In cycle i, sram_re=1, sram_we=0, sram_addr=i. The expected value pattern(i) and a valid bit are delayed RD_LAT cycles through a shift pipeline. After i=DEPTH-1, go to DRAIN.
- DRAIN: lasts RD_LAT cycles with we=re=0 and sram_addr holding its last value. The compare continues until the pipeline is empty.
- DONE: one cycle. done=1, busy=0, pass=(err_count==0). Next state is IDLE.
- Compare: whenever a pipelined valid bit is 1, check sram_outbits != expected. On a mismatch, err_count increments by 1. If it is the first mismatch, fail_addr takes the delayed address. err_count cannot overflow (max 128).
- Patterns (addr zero-extended to DW):
  - mode 0: {9'h000, addr}.
  - mode 1: checkerboard, 16'h5555 for even addresses, 16'hAAAA for odd.
  - mode 2: 16-bit Fibonacci LFSR, taps 16,14,13,11. It starts at seed (a seed of 0 is replaced by 16'h0001) and advances once per word. It is reloaded to the same start value at the entry to READ so the read sequence regenerates the written data.
  - mode 3: bitwise inverse of mode 0.
- Latency: if start is sampled at edge 0, the first write is at cycle 1, the first read at cycle DEPTH+1, and done at cycle 2*DEPTH+RD_LAT+1 (258 for the defaults).
- we and re are never both 1.

Test Plan:
- Fault-free SRAM model (RD_LAT=1), mode 0, pulse start -> 128 writes with sram_inbits=addr, then 128 reads; done at cycle 258; pass=1, err_count=0, fail_addr=0.
- Same model with bit 3 stuck-at-0 at addr 7'h15, mode 3 (expected 16'hFFEA) -> pass=0, err_count=1, fail_addr=7'h15. Rerun in mode 0 -> pass=1.
- Mode 2, seed=16'h0000 -> the first written word is 16'h0001. With a fault-free model, pass=1. Confirm that the read-phase expected values equal the write-phase data sequence.
- Model with addr 7'h40 and 7'h41 aliased, mode 1 -> err_count=1 (addr 7'h40 reads 16'hAAAA), fail_addr=7'h40, pass=0.
- Drive rst=0 during READ at i=50 -> at the next edge busy, we, re, done and err_count are 0 and the state is IDLE. A new start afterwards runs a full test to done.
- Pulse start again at cycle 10 while busy -> ignored; exactly one done pulse at cycle 258; mode and seed are unchanged.
